// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared RV32 pipeline constants and branch-predictor counter encoding
package cpu_defs;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : ctr_t'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/fetch_stage_btb.sv
// btb: direct-mapped branch target buffer with 2-bit counters, combinational lookup and clocked update
module btb
    import cpu_defs::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX = $clog2(ENTRIES),
    localparam int TW = XLEN - IDX - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);
    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];
    ctr_t               ctr    [ENTRIES];
    logic [IDX-1:0]     li, ui;
    logic [TW-1:0]      lt, ut;
    logic               uhit;

    always_comb begin
        li = IDX'(pc >> 2);
        lt = TW'(pc >> (IDX + 2));
        ui = IDX'(upd_pc >> 2);
        ut = TW'(upd_pc >> (IDX + 2));
        uhit = valid[ui] && tag[ui] == ut;
        pred_taken = valid[li] && tag[li] == lt && ctr[li][1];
        pred_target = target[li];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
        end else if (upd_valid) begin
            if (uhit) ctr[ui] <= ctr_next(ctr[ui], upd_taken);
            else if (upd_taken) begin
                valid[ui] <= 1'b1;
                ctr[ui] <= WT;
            end
        end
    end

    // A taken update either refreshes a hit (same tag) or allocates, so tag and target are written alike.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag[ui] <= ut;
            target[ui] <= upd_target;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with PC register, BTB next-PC prediction and IF/ID latch
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int BTB_ENTRIES = 16,
    parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        halt_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);
    logic [31:0] pc, next_pc, pred_target;
    logic        pred_taken;

    btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign imem_addr = pc;
    assign next_pc = pred_taken ? pred_target : pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            id_valid <= 1'b0;
            id_pc <= '0;
            id_inst <= NOP_INST;
            id_pred_taken <= 1'b0;
            id_pred_target <= '0;
        end else if (redirect) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
            id_valid <= 1'b0;
            id_inst <= NOP_INST;
            id_pred_taken <= 1'b0;
        end else if (!(stall || halt_in)) begin
            pc <= next_pc;
            id_valid <= 1'b1;
            id_pc <= pc;
            id_inst <= imem_data;
            id_pred_taken <= pred_taken;
            id_pred_target <= next_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural fetch/BTB model
module tb_fetch_stage;
    logic        clk = 0, rst = 0;
    logic [31:0] imem_addr, imem_data, redirect_pc = 0, upd_pc = 0, upd_target = 0;
    logic        stall = 0, halt_in = 0, redirect = 0, upd_valid = 0, upd_taken = 0;
    logic        id_valid, id_pred_taken;
    logic [31:0] id_pc, id_inst, id_pred_target;
    int          errors = 0, checks = 0;

    logic [31:0] m_pc, m_idpc, m_inst, m_ptgt;
    logic        m_v, m_pt;
    bit          b_valid [16];
    logic [31:0] b_tag [16], b_tgt [16];
    int          b_ctr [16];

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .halt_in(halt_in), .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_v = 0; m_idpc = 0; m_inst = 32'h13; m_pt = 0; m_ptgt = 0;
        for (int i = 0; i < 16; i++) begin
            b_valid[i] = 0;
            b_ctr[i] = 1;
        end
    endtask

    task automatic model_edge();
        int i, u;
        bit pt;
        logic [31:0] np;
        i = int'((m_pc >> 2) % 16);
        pt = b_valid[i] && b_tag[i] == (m_pc >> 6) && b_ctr[i] >= 2;
        np = pt ? b_tgt[i] : m_pc + 32'd4;
        if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_v = 0; m_inst = 32'h13; m_pt = 0;
        end else if (!(stall || halt_in)) begin
            m_idpc = m_pc; m_inst = mem_word(m_pc); m_pt = pt; m_ptgt = np; m_v = 1; m_pc = np;
        end
        if (upd_valid) begin
            u = int'((upd_pc >> 2) % 16);
            if (b_valid[u] && b_tag[u] == (upd_pc >> 6)) begin
                b_ctr[u] = upd_taken ? (b_ctr[u] == 3 ? 3 : b_ctr[u] + 1) : (b_ctr[u] == 0 ? 0 : b_ctr[u] - 1);
                if (upd_taken) b_tgt[u] = upd_target;
            end else if (upd_taken) begin
                b_valid[u] = 1; b_tag[u] = upd_pc >> 6; b_tgt[u] = upd_target; b_ctr[u] = 2;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, m_v});
        chk("id_pc", id_pc, m_idpc);
        chk("id_inst", id_inst, m_inst);
        chk("id_pred_taken", {31'b0, id_pred_taken}, {31'b0, m_pt});
        chk("id_pred_target", id_pred_target, m_ptgt);
    endtask

    task automatic step(input bit st, input bit ht, input bit rd, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
        stall = st; halt_in = ht; redirect = rd; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] a, input bit t, input logic [31:0] tg);
        step(0, 0, 0, 0, 1, a, t, tg);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_inst", id_inst, 32'h13);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check_all();
        @(negedge clk);
        rst = 1;
        repeat (3) idle();
        chk("seq_id_pc", id_pc, 32'h8);
        chk("seq_id_valid", {31'b0, id_valid}, 32'h1);
        chk("seq_imem_addr", imem_addr, 32'hC);
        idle();
        for (int k = 0; k < 3; k++) begin
            step(k < 2, k == 2, 0, 0, 0, 0, 0, 0);
            chk("hold_imem_addr", imem_addr, 32'h10);
            chk("hold_id_pc", id_pc, 32'hC);
        end
        idle();
        chk("resume_imem_addr", imem_addr, 32'h14);
        step(1, 0, 1, 32'h103, 0, 0, 0, 0);
        chk("redir_imem_addr", imem_addr, 32'h100);
        chk("redir_id_valid", {31'b0, id_valid}, 32'h0);
        chk("redir_id_inst", id_inst, 32'h13);
        jump(32'hFFFF_FFFC);
        idle();
        chk("wrap_imem_addr", imem_addr, 32'h0);
        train(32'h20, 1, 32'h80);
        jump(32'h20);
        idle();
        chk("btb_taken_addr", imem_addr, 32'h80);
        chk("btb_pred_taken", {31'b0, id_pred_taken}, 32'h1);
        chk("btb_pred_target", id_pred_target, 32'h80);
        train(32'h20, 0, 0);
        train(32'h20, 0, 0);
        jump(32'h20);
        idle();
        chk("btb_nt_addr", imem_addr, 32'h24);
        train(32'h20, 1, 32'h80);
        jump(32'h20);
        idle();
        chk("btb_weak_addr", imem_addr, 32'h24);
        train(32'h20, 1, 32'h80);
        jump(32'h20);
        idle();
        chk("btb_retrain_addr", imem_addr, 32'h80);
        train(32'h60, 1, 32'h200);
        jump(32'h60);
        idle();
        chk("alias_new_addr", imem_addr, 32'h200);
        chk("alias_pred_taken", {31'b0, id_pred_taken}, 32'h1);
        jump(32'h20);
        idle();
        chk("alias_old_addr", imem_addr, 32'h24);
        #2 rst = 0;
        #1;
        chk("async_rst_imem_addr", imem_addr, 32'h0);
        chk("async_rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("async_rst_id_inst", id_inst, 32'h13);
        model_reset();
        @(negedge clk);
        rst = 1;
        jump(32'h20);
        train(32'h20, 1, 32'h80);
        chk("same_cycle_addr", imem_addr, 32'h24);
        chk("same_cycle_pred", {31'b0, id_pred_taken}, 32'h0);
        jump(32'h20);
        idle();
        chk("same_cycle_next_visit", imem_addr, 32'h80);
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 511), $urandom_range(0, 4) < 2,
                 ($urandom_range(0, 127) << 2) | ($urandom_range(0, 3) == 0 ? 32'h400 : 32'h0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 127) << 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the pipelined RV32 CPU. It sits directly upstream of decode.
- Owns the PC and drives the instruction-memory address.
- Predicts the next PC with a small direct-mapped BTB holding 2-bit counters.
- Registers the IF/ID pipeline latch consumed by decode.
- Accepts stall, halt and mispredict-redirect/training inputs from later stages.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
BTB_ENTRIES, 16, BTB entries; power of two, at least 2; IDX = log2(BTB_ENTRIES)
NOP_INST, 32'h00000013, instruction word (addi x0,x0,0) placed in id_inst for a bubble

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_addr  out  32  current PC to IMEM; combinational read
imem_data  in  32  instruction word at imem_addr, same cycle
stall  in  1  hold PC and IF/ID latch
halt_in  in  1  CPU halting; freeze fetch
redirect  in  1  EX-stage mispredict; load redirect_pc
redirect_pc  in  32  corrected PC
upd_valid  in  1  resolved control-flow update from EX
upd_pc  in  32  PC of the resolved instruction
upd_taken  in  1  actual direction
upd_target  in  32  actual target
id_valid  out  1  IF/ID latch holds a real instruction
id_pc  out  32  PC of latched instruction
id_inst  out  32  latched instruction word
id_pred_taken  out  1  prediction made for id_pc
id_pred_target  out  32  predicted next PC for id_pc (PC+4 if not taken)

Behaviour:
- Reset (rst=0, async, effective immediately, including mid-operation):
  - PC=RESET_PC
  - id_valid=0, id_pc=0, id_inst=NOP_INST, id_pred_taken=0, id_pred_target=0
  - all BTB valid bits=0, all counters=2'b01
- imem_addr = PC at all times, with no register stage.
- Lookup, combinational on the current PC:
  - idx = PC[IDX+1:2], tag = PC[31:IDX+2]
  - hit = valid[idx] & tag match
  - pred_taken = hit & ctr[idx][1]
  - next_pc = pred_taken ? target[idx] : PC+4; PC+4 wraps modulo 2^32
- Per-edge priority, highest first:
  1. redirect=1: PC<=redirect_pc with bits [1:0] forced to 0. IF/ID becomes a bubble (id_valid=0, id_inst=NOP_INST, id_pred_taken=0). Stall and halt are ignored.
  2. stall=1 or halt_in=1: PC and all id_* hold.
  3. Otherwise: PC<=next_pc and id_valid<=1, id_pc<=PC, id_inst<=imem_data, id_pred_taken<=pred_taken, id_pred_target<=next_pc.
- BTB update happens at the clock edge when upd_valid=1 and is independent of stall, halt and redirect. It uses idx and tag computed from upd_pc.
  - Hit: counter saturating-increments if taken, saturating-decrements if not, bounded 00..11. Target <= upd_target when taken.
  - Miss and taken: allocate/replace the entry with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss and not taken: no change.
- Lookup and update at the same index in the same cycle: the lookup sees the pre-update contents; the update is visible from the next cycle.
- Latency: a redirect at edge N puts redirect_pc on imem_addr after edge N; that instruction appears in id_* after edge N+1 unless stalled.
- No internal state other than PC, the IF/ID latch and the BTB arrays.

Decomposition:
- Shared package, cpu_defs:
  - XLEN=32, NOP_INST, RESET_PC
  - BTB counter encodings: SNT=00, WNT=01, WT=10, ST=11
- Sub-module btb:
  - arrays, combinational lookup port, clocked update port, async clear
- fetch_stage instantiates btb and holds the PC register and IF/ID latch.

Test Plan:
- Reset/sequential fetch: hold rst=0, then release → imem_addr=0, id_valid=0, id_inst=00000013 during reset. After 3 edges: id_pc=8, id_valid=1, imem_addr=0x0C.
- Stall/halt hold: stall=1 for 2 cycles at PC=0x10, then halt_in=1 for 1 cycle → imem_addr stays 0x10 and id_pc stays 0x0C throughout; fetch resumes at 0x14 only after both inputs drop.
- Redirect beats stall: stall=1, redirect=1, redirect_pc=0x103 → next cycle imem_addr=0x100, id_valid=0, id_inst=NOP_INST. Redirect to 0xFFFFFFFC → the following sequential PC is 0x00000000.
- BTB train: upd_valid, upd_pc=0x20, taken, target=0x80 → when PC reaches 0x20, next imem_addr=0x80, id_pred_taken=1, id_pred_target=0x80.
  - Then two not-taken updates for 0x20 (ctr 10→01→00) → predicts 0x24.
  - Then one taken update (00→01) → still predicts 0x24.
- Alias replacement (16 entries): after training 0x20→0x80, send a taken update upd_pc=0x60, target=0x200 (same idx 8) → 0x60 predicts 0x200 with ctr=10; 0x20 now misses and predicts 0x24.
- Same-cycle update/lookup: PC=0x20 while a taken update for 0x20 arrives on an empty BTB → that cycle predicts 0x24; the next visit to 0x20 predicts the trained target.
